// File: rtl/pipe_pkg.sv
// pipe_pkg: opcode constants and FSM state type shared by the pipeline control block.
package pipe_pkg;

    localparam logic [3:0] OP_LW    = 4'd0;
    localparam logic [3:0] OP_SW    = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_MOV   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_JMPZ  = 4'd5;
    localparam logic [3:0] OP_STOP  = 4'd7;
    localparam logic [3:0] OP_ADDF  = 4'd8;
    localparam logic [3:0] OP_MULTF = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_NOP   = 4'd15;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FP_WAIT = 2'd1,
        DRAIN   = 2'd2,
        HALT    = 2'd3
    } state_e;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator.
//   id_opcode_i, id_rs_i, id_rt_i : instruction in ID
//   ex_memread_i, ex_rd_i         : LW flag and destination of the instruction in EX
//   hazard_o                      : ID consumes the register a LW in EX is still loading
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int OP_WIDTH = 4,
    parameter int RA_WIDTH = 4
) (
    input  logic [OP_WIDTH-1:0] id_opcode_i,
    input  logic [RA_WIDTH-1:0] id_rs_i,
    input  logic [RA_WIDTH-1:0] id_rt_i,
    input  logic                ex_memread_i,
    input  logic [RA_WIDTH-1:0] ex_rd_i,
    output logic                hazard_o
);

    // NOP, STOP and JMPZ never read rs/rt as operands, so they cannot be load-use victims
    always_comb begin
        hazard_o = ex_memread_i
                && (ex_rd_i == id_rs_i || ex_rd_i == id_rt_i)
                && id_opcode_i != OP_WIDTH'(OP_NOP)
                && id_opcode_i != OP_WIDTH'(OP_STOP)
                && id_opcode_i != OP_WIDTH'(OP_JMPZ);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard / FP-occupancy / stop control FSM.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   id_opcode_i, id_rs_i, id_rt_i      : instruction in ID
//   ex_memread_i, ex_rd_i              : LW in EX and its destination
//   branch_taken_i                     : JMPZ resolved taken in EX
//   stall_if_o, stall_id_o, stall_ex_o : hold PC, IF/ID, ID/EX
//   flush_id_o, flush_ex_o             : insert NOP into IF/ID, ID/EX
//   fp_start_o, fp_busy_o              : FP launch pulse, FP unit occupying EX
//   halted_o, state_o                  : stopped flag, current FSM state
// Macro PIPE_CTRL_FP_EN enables multi-cycle ADDF/MULTF; otherwise they are single-cycle.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int OP_WIDTH  = 4,
    parameter int RA_WIDTH  = 4,
    parameter int FP_LAT    = 4,
    parameter int DRAIN_CYC = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OP_WIDTH-1:0] id_opcode_i,
    input  logic [RA_WIDTH-1:0] id_rs_i,
    input  logic [RA_WIDTH-1:0] id_rt_i,
    input  logic                ex_memread_i,
    input  logic [RA_WIDTH-1:0] ex_rd_i,
    input  logic                branch_taken_i,
    output logic                stall_if_o,
    output logic                stall_id_o,
    output logic                stall_ex_o,
    output logic                flush_id_o,
    output logic                flush_ex_o,
    output logic                fp_start_o,
    output logic                fp_busy_o,
    output logic                halted_o,
    output logic [1:0]          state_o
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       fp_busy_q, fp_busy_d;
    logic       halted_q, halted_d;
    logic       load_use, is_fp, is_stop;

    hazard_detect #(
        .OP_WIDTH(OP_WIDTH),
        .RA_WIDTH(RA_WIDTH)
    ) u_hazard (
        .id_opcode_i (id_opcode_i),
        .id_rs_i     (id_rs_i),
        .id_rt_i     (id_rt_i),
        .ex_memread_i(ex_memread_i),
        .ex_rd_i     (ex_rd_i),
        .hazard_o    (load_use)
    );

    assign is_stop = id_opcode_i == OP_WIDTH'(OP_STOP);

`ifdef PIPE_CTRL_FP_EN
    logic ready_q, ready_d;

    // Low for the first cycle after reset so an FP op aborted by reset is not relaunched
    always_comb begin
        ready_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= ready_d;
    end

    assign is_fp = ready_q && (id_opcode_i == OP_WIDTH'(OP_ADDF) || id_opcode_i == OP_WIDTH'(OP_MULTF));
`else
    assign is_fp = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            cnt_q     <= 4'd0;
            fp_busy_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fp_busy_q <= fp_busy_d;
            halted_q  <= halted_d;
        end
    end

    // FP_WAIT holds FP_LAT-1 cycles after the issue cycle; DRAIN holds DRAIN_CYC cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!branch_taken_i && !load_use) begin
                    if (is_fp) begin
                        state_d = FP_WAIT;
                        cnt_d   = 4'(FP_LAT - 1);
                    end else if (is_stop) begin
                        state_d = DRAIN;
                        cnt_d   = 4'(DRAIN_CYC);
                    end
                end
            end
            FP_WAIT, DRAIN: begin
                cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                if (cnt_q <= 4'd1) state_d = (state_q == FP_WAIT) ? RUN : HALT;
            end
            default: ;
        endcase
        fp_busy_d = state_d == FP_WAIT;
        halted_d  = state_d == HALT;
    end

    always_comb begin
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        stall_ex_o = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        fp_start_o = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (branch_taken_i) begin
                        flush_id_o = 1'b1;
                        flush_ex_o = 1'b1;
                    end else if (load_use) begin
                        stall_if_o = 1'b1;
                        stall_id_o = 1'b1;
                        flush_ex_o = 1'b1;
                    end else begin
                        fp_start_o = is_fp;
                    end
                end
                FP_WAIT: begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                end
                DRAIN: begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    flush_ex_o = 1'b1;
                end
                default: begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                end
            endcase
        end
    end

    assign fp_busy_o = fp_busy_q;
    assign halted_o  = halted_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl (FP scenarios follow PIPE_CTRL_FP_EN).
module tb_pipe_ctrl;
    import pipe_pkg::*;

    typedef struct packed {
        logic       rn;
        logic [3:0] op;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       mr;
        logic [3:0] rd;
        logic       br;
        logic [9:0] e;
    } step_t;

    // expected flag groups: {stall_if, stall_id, stall_ex, flush_id, flush_ex, fp_start, fp_busy, halted}
    localparam logic [7:0] IDLE = 8'b00000000;
    localparam logic [7:0] LU   = 8'b11001000;
    localparam logic [7:0] BR   = 8'b00011000;
    localparam logic [7:0] FS   = 8'b00000100;
    localparam logic [7:0] FPW  = 8'b11100010;
    localparam logic [7:0] DRN  = 8'b11001000;
    localparam logic [7:0] HLT  = 8'b11100001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] id_opcode = OP_NOP, id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       ex_memread = 1'b0, branch_taken = 1'b0;
    logic       stall_if, stall_id, stall_ex, flush_id, flush_ex, fp_start, fp_busy, halted;
    logic [1:0] state;
    logic [9:0] obs;
    logic [9:0] sb[$];
    int         n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.OP_WIDTH(4), .RA_WIDTH(4), .FP_LAT(4), .DRAIN_CYC(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode_i(id_opcode), .id_rs_i(id_rs), .id_rt_i(id_rt),
        .ex_memread_i(ex_memread), .ex_rd_i(ex_rd), .branch_taken_i(branch_taken),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
        .flush_id_o(flush_id), .flush_ex_o(flush_ex),
        .fp_start_o(fp_start), .fp_busy_o(fp_busy), .halted_o(halted), .state_o(state)
    );

    assign obs = {state, stall_if, stall_id, stall_ex, flush_id, flush_ex, fp_start, fp_busy, halted};

    function automatic step_t mk(input logic rn, input logic [3:0] op, rs, rt, input logic mr,
                                 input logic [3:0] rd, input logic br, input logic [1:0] st,
                                 input logic [7:0] f);
        return '{rn: rn, op: op, rs: rs, rt: rt, mr: mr, rd: rd, br: br, e: {st, f}};
    endfunction

    // drives one cycle of stimulus just after the rising edge and records its expectation
    task automatic apply(input step_t s);
        @(posedge clk);
        #1;
        rst_n = s.rn; id_opcode = s.op; id_rs = s.rs; id_rt = s.rt;
        ex_memread = s.mr; ex_rd = s.rd; branch_taken = s.br;
        sb.push_back(s.e);
    endtask

    task automatic test_reset;
        step_t s[$];
        logic [9:0] e;
        s.push_back(mk(0, OP_ADD, 3, 0, 1, 3, 0, 0, IDLE));
        s.push_back(mk(0, OP_NOP, 0, 0, 0, 0, 1, 0, IDLE));
        s.push_back(mk(1, OP_NOP, 0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_NOP, 0, 0, 0, 0, 0, 0, IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL reset[%0d]: got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_load_use;
        step_t s[$];
        logic [9:0] e;
        s.push_back(mk(1, OP_ADD,  3, 5, 1, 3, 0, 0, LU));
        s.push_back(mk(1, OP_ADD,  3, 5, 0, 3, 0, 0, IDLE));
        s.push_back(mk(1, OP_SUB,  1, 7, 1, 7, 0, 0, LU));
        s.push_back(mk(1, OP_SLT,  1, 2, 1, 7, 0, 0, IDLE));
        s.push_back(mk(1, OP_NOP,  3, 3, 1, 3, 0, 0, IDLE));
        s.push_back(mk(1, OP_JMPZ, 3, 3, 1, 3, 0, 0, IDLE));
        s.push_back(mk(1, OP_SW,   4, 9, 1, 9, 0, 0, LU));
        s.push_back(mk(1, OP_NOP,  0, 0, 0, 0, 0, 0, IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL load_use[%0d]: got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_branch;
        step_t s[$];
        logic [9:0] e;
        s.push_back(mk(1, OP_ADD,   3, 5, 1, 3, 1, 0, BR));
        s.push_back(mk(1, OP_STOP,  0, 0, 0, 0, 1, 0, BR));
        s.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_MULTF, 0, 0, 0, 0, 1, 0, BR));
        s.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 0, 0, IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL branch[%0d]: got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_fp;
        step_t s[$];
        logic [9:0] e;
`ifdef PIPE_CTRL_FP_EN
        s.push_back(mk(1, OP_MULTF, 0, 0, 0, 0, 0, 0, FS));
        s.push_back(mk(1, OP_MULTF, 3, 3, 1, 3, 1, 1, FPW));
        s.push_back(mk(1, OP_ADD,   3, 3, 1, 3, 0, 1, FPW));
        s.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 1, 1, FPW));
        s.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_ADDF,  0, 0, 0, 0, 0, 0, FS));
        s.push_back(mk(0, OP_ADDF,  0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_ADDF,  0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_NOP,   0, 0, 0, 0, 0, 0, IDLE));
`else
        s.push_back(mk(1, OP_ADDF,  1, 2, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_MULTF, 1, 2, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_ADD,   1, 2, 0, 0, 0, 0, IDLE));
`endif
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL fp[%0d]: got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_drain_abort;
        step_t s[$];
        logic [9:0] e;
        s.push_back(mk(1, OP_STOP, 0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_NOP,  0, 0, 0, 0, 0, 2, DRN));
        s.push_back(mk(0, OP_NOP,  0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_NOP,  0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_NOP,  0, 0, 0, 0, 0, 0, IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL drain_abort[%0d]: got %b want %b", i, obs, e); end
        end
    endtask

    task automatic test_stop_halt;
        step_t s[$];
        logic [9:0] e;
        // STOP is exempt from load-use, so matching LW operands must not delay it
        s.push_back(mk(1, OP_STOP, 3, 3, 1, 3, 0, 0, IDLE));
        s.push_back(mk(1, OP_ADD,  3, 3, 1, 3, 0, 2, DRN));
        s.push_back(mk(1, OP_NOP,  0, 0, 0, 0, 1, 2, DRN));
        s.push_back(mk(1, OP_NOP,  0, 0, 0, 0, 0, 2, DRN));
        for (int k = 0; k < 20; k++)
            s.push_back(mk(1, (k % 2) ? OP_MULTF : OP_STOP, 4'(k), 4'(k), 1'(k % 3 == 0), 4'(k), 1'(k % 2), 3, HLT));
        s.push_back(mk(0, OP_NOP,  0, 0, 0, 0, 0, 0, IDLE));
        s.push_back(mk(1, OP_NOP,  0, 0, 0, 0, 0, 0, IDLE));
        foreach (s[i]) begin
            apply(s[i]);
            @(negedge clk);
            e = sb.pop_front(); n_run++;
            if (obs !== e) begin n_fail++; $display("FAIL stop_halt[%0d]: got %b want %b", i, obs, e); end
        end
    endtask

    initial begin
        test_reset;
        test_load_use;
        test_branch;
        test_fp;
        test_drain_abort;
        test_stop_halt;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard: %0d left, want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have parameter OP_WIDTH, default 4, opcode width.
REQ-002 The block SHALL have parameter RA_WIDTH, default 4, register-address width.
REQ-003 The block SHALL have parameter FP_LAT, default 4, floating-point EX occupancy in cycles; the legal range is 2..15.
REQ-004 The block SHALL have parameter DRAIN_CYC, default 3, cycles needed to retire instructions older than STOP.
REQ-005 Port clk, input, 1 bit: the single clock. All state SHALL update on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port id_opcode_i, input, OP_WIDTH bits: opcode of the instruction in ID.
REQ-008 Ports id_rs_i and id_rt_i, input, RA_WIDTH bits each: source registers of the instruction in ID.
REQ-009 Port ex_memread_i, input, 1 bit: the instruction in EX is LW.
REQ-010 Port ex_rd_i, input, RA_WIDTH bits: destination register of the instruction in EX.
REQ-011 Port branch_taken_i, input, 1 bit: JMPZ resolved taken in EX.
REQ-012 Outputs stall_if_o, stall_id_o and stall_ex_o, 1 bit each: hold the PC, IF/ID and ID/EX registers respectively.
REQ-013 Outputs flush_id_o and flush_ex_o, 1 bit each: insert a NOP into IF/ID and ID/EX respectively.
REQ-014 Output fp_start_o, 1 bit: one-cycle launch pulse to the FP unit.
REQ-015 Output fp_busy_o, 1 bit: FP unit occupying EX.
REQ-016 Output halted_o, 1 bit: the processor is stopped.
REQ-017 Output state_o, 2 bits: current FSM state.

Function
REQ-018 The FSM SHALL have four states: RUN=0, FP_WAIT=1, DRAIN=2, HALT=3.
REQ-019 Load-use hazard, evaluated in RUN only: ex_memread_i && (ex_rd_i==id_rs_i || ex_rd_i==id_rt_i) && id_opcode_i not in {NOP, STOP, JMPZ}.
REQ-020 A load-use hazard SHALL assert stall_if_o, stall_id_o and flush_ex_o combinationally in the same cycle, for exactly one cycle.
REQ-021 branch_taken_i in RUN SHALL assert flush_id_o and flush_ex_o in the same cycle, SHALL override the load-use stall, and SHALL suppress FP issue and STOP detection for that cycle.
REQ-022 FP issue: in RUN, with id_opcode_i in {ADDF, MULTF}, no flush and no stall, fp_start_o SHALL be 1 for that cycle. The next state SHALL be FP_WAIT, and the counter SHALL load FP_LAT-1.
REQ-023 FP_WAIT: stall_if_o, stall_id_o, stall_ex_o and fp_busy_o SHALL all be 1, and the counter SHALL decrement each cycle. On the cycle the counter equals 1, the next state SHALL be RUN. Total EX occupancy SHALL be exactly FP_LAT cycles.
REQ-024 In FP_WAIT, branch_taken_i and load-use SHALL be ignored; the FP op blocks all younger instructions.
REQ-025 STOP: in RUN, with id_opcode_i==STOP and no flush, the next state SHALL be DRAIN and the counter SHALL load DRAIN_CYC. A load-use stall on the same cycle defers STOP to the next cycle.
REQ-026 DRAIN: stall_if_o and stall_id_o SHALL be 1 and flush_ex_o SHALL be 1 (bubbles); the counter SHALL decrement. At 1 the next state SHALL be HALT. branch_taken_i SHALL be ignored.
REQ-027 HALT: halted_o SHALL be 1 and all stall outputs SHALL be 1. The block SHALL leave HALT only by reset.
REQ-028 Counter width SHALL be 4 bits, and it SHALL never underflow.
REQ-029 Outputs not named active for the current state and condition SHALL be 0.

Reset
REQ-030 While rst_n==0, asynchronously: state=RUN, counter=0, and the registered fp_busy_o and halted_o SHALL be 0.
REQ-031 Combinational outputs SHALL be 0 while rst_n==0.
REQ-032 Reset in FP_WAIT or DRAIN SHALL abort the operation, with no fp_start_o on the following cycle.

Configuration
REQ-033 With macro PIPE_CTRL_FP_EN defined, ADDF/MULTF SHALL follow REQ-022..024.
REQ-034 Without PIPE_CTRL_FP_EN, ADDF/MULTF SHALL be single-cycle: fp_start_o and fp_busy_o tied to 0, FP_WAIT unreachable, FP_LAT unused.

Structure
REQ-035 Package pipe_pkg SHALL hold the opcode constants (LW=0, SW=1, ADD=2, MOV=3, SUB=4, JMPZ=5, STOP=7, ADDF=8, MULTF=9, SLT=10, NOP=15) and the 2-bit state type.
REQ-036 The load-use comparator (REQ-019) SHALL be sub-module hazard_detect, purely combinational; pipe_ctrl SHALL own the FSM and counter.

Verification
REQ-037 LW r3 in EX, ID=ADD rs=3 -> stall_if_o/stall_id_o/flush_ex_o =1 for one cycle; 0 the next cycle.
REQ-038 Same load-use cycle with branch_taken_i=1 -> flush_id_o=flush_ex_o=1, stall_if_o=0.
REQ-039 FP_LAT=4, ID=MULTF -> fp_start_o pulse on cycle 0, stall_ex_o=1 cycles 1-3, state_o=0 on cycle 4.
REQ-040 ID=STOP, DRAIN_CYC=3 -> state_o=2 for 3 cycles, then halted_o=1 held for 20 cycles, stable.
REQ-041 rst_n low mid FP_WAIT -> state_o=0 and fp_busy_o=0 immediately; without PIPE_CTRL_FP_EN, ADDF -> no stall.
